sd_dma_byte_sink: RTL

- Wishbone classic slave that receives block data from the SD controller's DMA master port (m_wb_*) during card reads.
- Buffers the 32-bit words in a FIFO and serialises them into a byte stream with valid/ready for the downstream frame decoder.
- Stalls the DMA master by withholding ack when the FIFO is full, so no data is ever dropped.
- Pulses a block-done strobe after every complete 512-byte sector has been accepted.

---
 rtl/sd_dma_byte_sink_pkg.sv | 12 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/sd_dma_byte_sink.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sd_dma_byte_sink_pkg.sv
// Shared constants and serialiser state encoding for the SD DMA byte sink.
package sd_dma_byte_sink_pkg;

    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_BLOCK_WORDS = SD_BLOCK_BYTES / 4;

    typedef enum logic {
        SER_EMPTY = 1'b0,
        SER_HOLD  = 1'b1
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; rd_data shows the head word combinationally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level is one bit wider to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sd_dma_byte_sink.sv
// Wishbone slave that buffers DMA words from the SD controller and streams them out as bytes,
// MSB first, with a one-cycle block_done strobe per completed sector.
module sd_dma_byte_sink
    import sd_dma_byte_sink_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int BLOCK_WORDS = SD_BLOCK_WORDS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic [31:0]        wb_dat_o,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               block_done,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_rd_data;
    logic [WCW-1:0]   word_cnt;
    ser_state_t       ser_state;
    ser_state_t       ser_state_next;
    logic [31:0]      hold;
    logic [31:0]      hold_next;
    logic [1:0]       byte_idx;
    logic [1:0]       byte_idx_next;
    logic             unused_inputs;

    // Address and byte selects carry no information for this sink; every access is a full word.
    assign unused_inputs = ^{wb_adr_i, wb_sel_i};
    assign wb_dat_o      = '0;

    assign fifo_push = wb_cyc_i & wb_stb_i & wb_we_i & ~wb_ack_o & ~fifo_full;

    sync_fifo #(
        .WIDTH (32),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (wb_dat_i),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Full comes from the registered level, so a same-cycle pop still delays the ack by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_o   <= 1'b0;
            word_cnt   <= '0;
            block_done <= 1'b0;
        end else begin
            wb_ack_o   <= wb_cyc_i & wb_stb_i & ~wb_ack_o & (~wb_we_i | ~fifo_full);
            block_done <= fifo_push && (word_cnt == WCW'(BLOCK_WORDS - 1));
            if (fifo_push) begin
                if (word_cnt == WCW'(BLOCK_WORDS - 1)) begin
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_state <= SER_EMPTY;
            hold      <= '0;
            byte_idx  <= '0;
        end else begin
            ser_state <= ser_state_next;
            hold      <= hold_next;
            byte_idx  <= byte_idx_next;
        end
    end

    // On the last byte of a word the next one is loaded directly, giving a gap-free stream.
    always_comb begin
        ser_state_next = ser_state;
        hold_next      = hold;
        byte_idx_next  = byte_idx;
        fifo_pop       = 1'b0;
        case (ser_state)
            SER_EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    hold_next      = fifo_rd_data;
                    byte_idx_next  = 2'd0;
                    ser_state_next = SER_HOLD;
                end
            end
            SER_HOLD: begin
                if (out_ready) begin
                    if (byte_idx == 2'd3) begin
                        if (!fifo_empty) begin
                            fifo_pop      = 1'b1;
                            hold_next     = fifo_rd_data;
                            byte_idx_next = 2'd0;
                        end else begin
                            ser_state_next = SER_EMPTY;
                        end
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                    end
                end
            end
            default: ser_state_next = SER_EMPTY;
        endcase
    end

    assign out_valid = (ser_state == SER_HOLD);
    assign out_data  = hold[{~byte_idx, 3'b000} +: 8];

endmodule
